// File: rtl/read_accounter.sv
// read_accounter: per-address record of which write bank holds the newest
// data, plus a registered read-request stage that attaches the bank selector
// (rdselect) each read agent needs at the read switch. Also flags write
// collisions (two write agents hitting the same address on one cycle).
//
// Optional feature: define ACCOUNTER_BYPASS_EN for write-first forwarding,
// where a read hitting an address written on the same cycle returns the
// highest writing agent instead of the pre-write table value.
//
// After srst the table is cleared by a sweep of 2**ADDR_WIDTH cycles; ready
// rises once the sweep is done and writes/reads are honoured from then on.
module read_accounter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT < 2) ? 1 : $clog2(NB_WRAGENT)
) (
  input  logic                             aclk,
  input  logic                             srst,
  output logic                             ready,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_RDAGENT-1:0]            rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT-1:0]            m_rden,
  output logic [NB_RDAGENT*ADDR_WIDTH-1:0] m_rdaddr,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
  output logic                             wr_collision,
  output logic                             collision_sticky
);

  localparam int                  DEPTH    = 2**ADDR_WIDTH;
  // cnt carries one extra bit so the terminal value never aliases to zero.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH:0]               cnt_q, cnt_d;
  logic                              ready_q, ready_d;
  logic [NB_RDAGENT-1:0]             m_rden_q, m_rden_d;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]  m_rdaddr_q, m_rdaddr_d;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect_q, rdselect_d;
  logic                              wr_collision_q, wr_collision_d;
  logic                              collision_sticky_q, collision_sticky_d;
  logic                              collide;

  // NOTE: the table is deliberately not reset here; the INIT sweep clears it
  // one entry per cycle, which keeps it mappable onto plain RAM.
  logic [SELECT_WIDTH-1:0]           table_mem [DEPTH];

  // Sweep sequencing: count through every entry, then enter RUN with ready.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end
  end

  // Collision detection: any pair of enabled write agents on one address.
  always_comb begin
    collide = 1'b0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NB_WRAGENT; i++) begin
        for (int k = i + 1; k < NB_WRAGENT; k++) begin
          if (wren[i] && wren[k] &&
              (wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == wraddr[ADDR_WIDTH*k +: ADDR_WIDTH])) begin
            collide = 1'b1;
          end
        end
      end
    end
    wr_collision_d     = collide;
    collision_sticky_d = collision_sticky_q | collide;
  end

  // Read stage: register requests and look up the owning bank per agent.
  always_comb begin
    m_rden_d   = (state_q == ST_RUN) ? rden : '0;
    m_rdaddr_d = rdaddr;
    rdselect_d = '0;
    for (int j = 0; j < NB_RDAGENT; j++) begin
      rdselect_d[SELECT_WIDTH*j +: SELECT_WIDTH] =
        table_mem[rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]];
`ifdef ACCOUNTER_BYPASS_EN
      // Write-first: ascending scan so the highest matching agent wins.
      if ((state_q == ST_RUN) && rden[j]) begin
        for (int i = 0; i < NB_WRAGENT; i++) begin
          if (wren[i] &&
              (wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH])) begin
            rdselect_d[SELECT_WIDTH*j +: SELECT_WIDTH] = SELECT_WIDTH'(i);
          end
        end
      end
`endif
    end
  end

  // Table update: clear during the sweep, record the writing bank in RUN.
  always_ff @(posedge aclk) begin
    if (!srst) begin
      if (state_q == ST_INIT) begin
        table_mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
      end else begin
        // Ascending order: the last assignment (highest agent) takes effect.
        for (int i = 0; i < NB_WRAGENT; i++) begin
          if (wren[i]) begin
            table_mem[wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= SELECT_WIDTH'(i);
          end
        end
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (srst) begin
      state_q            <= ST_INIT;
      cnt_q              <= '0;
      ready_q            <= 1'b0;
      m_rden_q           <= '0;
      m_rdaddr_q         <= '0;
      rdselect_q         <= '0;
      wr_collision_q     <= 1'b0;
      collision_sticky_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      ready_q            <= ready_d;
      m_rden_q           <= m_rden_d;
      m_rdaddr_q         <= m_rdaddr_d;
      rdselect_q         <= rdselect_d;
      wr_collision_q     <= wr_collision_d;
      collision_sticky_q <= collision_sticky_d;
    end
  end

  assign ready            = ready_q;
  assign m_rden           = m_rden_q;
  assign m_rdaddr         = m_rdaddr_q;
  assign rdselect         = rdselect_q;
  assign wr_collision     = wr_collision_q;
  assign collision_sticky = collision_sticky_q;

endmodule
